// File: rtl/adder_check_engine.sv
// Self-checking stimulus/compare engine for N-bit adders: drives exhaustive or
// LFSR-random operands, compares against a delayed reference, logs first error.
module adder_check_engine #(
    parameter int unsigned N           = 16,
    parameter int unsigned LATENCY     = 0,
    parameter int unsigned NUM_VECTORS = 30000,
    parameter bit          CHECK_PG    = 1'b1,
    parameter logic [31:0] SEED        = 32'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    output logic [N-1:0]   a,
    output logic [N-1:0]   b,
    output logic           cin,
    input  logic [N-1:0]   s_duv,
    input  logic           cout_duv,
    input  logic           prop_duv,
    input  logic           gen_duv,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [15:0]    err_count,
    output logic [31:0]    first_err_idx,
    output logic [2*N:0]   first_err_vec
);

    localparam int unsigned VW       = 2 * N + 1;
    localparam bit          EXH_OK   = (VW <= 32);
    localparam logic [31:0] TAPS     = 32'h80200003;
    localparam logic [31:0] LAST_EXH = 32'((64'd1 << VW) - 64'd1);
    localparam logic [31:0] LAST_RND = 32'(NUM_VECTORS - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic          valid;
        logic [N-1:0]  s;
        logic          cout;
        logic          prop;
        logic          gen;
        logic [31:0]   idx;
        logic [VW-1:0] vec;
    } exp_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : 32'd0);
    endfunction

    state_e        state_q, state_d;
    logic [31:0]   idx_q, idx_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic          mode_q, mode_d;
    logic [2:0]    drain_q, drain_d;
    logic          vld_q, vld_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic          cin_q, cin_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]   err_q, err_d;
    logic [31:0]   fidx_q, fidx_d;
    logic [VW-1:0] fvec_q, fvec_d;

    logic          issue, start_acc, exh, mism;
    logic [31:0]   last_idx;
    logic [VW-1:0] vec_exh;
    logic [N-1:0]  b_rnd;
    logic [N:0]    sum_full, ab_full;
    exp_t          cur, cmp;

    assign last_idx = (mode_q && EXH_OK) ? LAST_EXH : LAST_RND;

    // Expected response of the vector currently on a/b/cin
    always_comb begin
        sum_full  = {1'b0, a_q} + {1'b0, b_q} + (N+1)'(cin_q);
        ab_full   = {1'b0, a_q} + {1'b0, b_q};
        cur.valid = vld_q;
        cur.s     = sum_full[N-1:0];
        cur.cout  = sum_full[N];
        cur.prop  = &(a_q ^ b_q);
        cur.gen   = ab_full[N];
        cur.idx   = idx_q;
        cur.vec   = {cin_q, a_q, b_q};
    end

    // Delay line aligning expectations with the DUT pipeline
    generate
        if (LATENCY == 0) begin : g_nolat
            assign cmp = cur;
        end else begin : g_lat
            exp_t pipe_q [LATENCY];
            exp_t pipe_d [LATENCY];
            always_comb begin
                pipe_d[0] = cur;
                for (int i = 1; i < int'(LATENCY); i++) pipe_d[i] = pipe_q[i-1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
                end else begin
                    for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= pipe_d[i];
                end
            end
            assign cmp = pipe_q[LATENCY-1];
        end
    endgenerate

    assign mism = cmp.valid &&
                  ((s_duv != cmp.s) || (cout_duv != cmp.cout) ||
                   (CHECK_PG && ((prop_duv != cmp.prop) || (gen_duv != cmp.gen))));

    // Next-state, stimulus and result logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lfsr_d    = lfsr_q;
        mode_d    = mode_q;
        drain_d   = drain_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        fvec_d    = fvec_q;
        issue     = 1'b0;
        start_acc = 1'b0;
        a_d       = '0;
        b_d       = '0;
        cin_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = S_RUN;
                    idx_d     = 32'd0;
                    lfsr_d    = SEED;
                    mode_d    = mode;
                    issue     = 1'b1;
                end
            end
            S_RUN: begin
                if (idx_q == last_idx) begin
                    state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    idx_d  = idx_q + 32'd1;
                    lfsr_d = lfsr_next(lfsr_q);
                    issue  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'(LATENCY - 1)) state_d = S_DONE;
                else                             drain_d = drain_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase

        exh     = mode_d && EXH_OK;
        vec_exh = VW'(idx_d);
        for (int i = 0; i < int'(N); i++) b_rnd[i] = lfsr_d[31-i];
        if (issue) begin
            a_d   = exh ? vec_exh[2*N-1:N] : lfsr_d[N-1:0];
            b_d   = exh ? vec_exh[N-1:0]   : b_rnd;
            cin_d = exh ? vec_exh[2*N]     : ^lfsr_d;
        end

        if (start_acc) begin
            err_d  = '0;
            fidx_d = '0;
            fvec_d = '0;
        end else if (mism) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) begin
                fidx_d = cmp.idx;
                fvec_d = cmp.vec;
            end
        end

        vld_d  = issue;
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lfsr_q  <= SEED;
            mode_q  <= 1'b0;
            drain_q <= '0;
            vld_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            drain_q <= drain_d;
            vld_q   <= vld_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fvec_q  <= fvec_d;
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign cin           = cin_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_vec = fvec_q;

endmodule

// File: tb/tb_adder_check_engine.sv
// Bench for adder_check_engine: a faultable bench-side adder feeds the engine,
// and a vector-list model predicts stimulus, timing and error reports.
module tb_adder_check_engine;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned NVR = 200;
    localparam int unsigned VW  = 2 * N + 1;

    logic           clk = 1'b0;
    logic           rst_n, start, mode;
    logic [N-1:0]   a, b, s_duv;
    logic           cin, cout_duv, prop_duv, gen_duv;
    logic           busy, done, pass;
    logic [15:0]    err_count;
    logic [31:0]    first_err_idx;
    logic [VW-1:0]  first_err_vec;

    // Second engine: 2-bit, no latency, prop/gen ignored
    logic           start2;
    logic [1:0]     a2, b2, s2;
    logic           cin2, cout2, busy2, done2, pass2;
    logic [15:0]    err2;
    logic [31:0]    fidx2;
    logic [4:0]     fvec2;

    int             fault;
    int             checks   = 0;
    int             failures = 0;
    logic [VW-1:0]  evec [$];
    int             exp_err;
    logic [31:0]    exp_fidx;
    logic [VW-1:0]  exp_fvec;
    logic [N+2:0]   dp [3];

    always #5 clk = ~clk;

    adder_check_engine #(.N(N), .LATENCY(LAT), .NUM_VECTORS(NVR), .CHECK_PG(1'b1),
                         .SEED(32'hACE1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .cin(cin),
        .s_duv(s_duv), .cout_duv(cout_duv), .prop_duv(prop_duv), .gen_duv(gen_duv),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vec(first_err_vec));

    adder_check_engine #(.N(2), .LATENCY(0), .NUM_VECTORS(5), .CHECK_PG(1'b0),
                         .SEED(32'hACE1)) u_pg (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(1'b1),
        .a(a2), .b(b2), .cin(cin2),
        .s_duv(s2), .cout_duv(cout2), .prop_duv(1'b0), .gen_duv(1'b0),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_idx(fidx2), .first_err_vec(fvec2));

    assign {cout2, s2} = {1'b0, a2} + {1'b0, b2} + 3'(cin2);

    // Correct adder response packed as {s, cout, prop, gen}
    function automatic logic [N+2:0] ref_resp(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic c);
        int unsigned t = int'(x) + int'(y) + int'(c);
        int unsigned g = int'(x) + int'(y);
        logic p = ((x ^ y) == {N{1'b1}});
        return {N'(t), t >= (1 << N), p, g >= (1 << N)};
    endfunction

    // Faults: 1 = s[0] stuck-at-0, 2 = gen inverted when a==b, 3 = one extra pipeline stage
    function automatic logic [N+2:0] dut_resp(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic c, input int f);
        logic [N+2:0] r = ref_resp(x, y, c);
        if (f == 1) r[3] = 1'b0;
        if (f == 2 && x == y) r[0] = ~r[0];
        return r;
    endfunction

    always @(posedge clk) begin
        dp[0] <= dut_resp(a, b, cin, fault);
        dp[1] <= dp[0];
        dp[2] <= dp[1];
    end
    assign {s_duv, cout_duv, prop_duv, gen_duv} = (fault == 3) ? dp[2] : dp[LAT-1];

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Vector list plus expected error report for one run
    task automatic build(input logic m, input int f);
        logic [31:0]  l = 32'hACE1;
        logic [N-1:0] va, vb;
        logic [N+2:0] got, want;
        evec.delete();
        if (m) begin
            for (int k = 0; k < (1 << VW); k++) evec.push_back(VW'(k));
        end else begin
            for (int k = 0; k < int'(NVR); k++) begin
                va = l[N-1:0];
                for (int i = 0; i < int'(N); i++) vb[i] = l[31-i];
                evec.push_back({^l, va, vb});
                l = lfsr_step(l);
            end
        end
        exp_err = 0; exp_fidx = '0; exp_fvec = '0;
        for (int k = 0; k < evec.size(); k++) begin
            want = ref_resp(evec[k][2*N-1:N], evec[k][N-1:0], evec[k][2*N]);
            if (f == 3) got = (k == 0) ? '0 : ref_resp(evec[k-1][2*N-1:N], evec[k-1][N-1:0],
                                                       evec[k-1][2*N]);
            else        got = dut_resp(evec[k][2*N-1:N], evec[k][N-1:0], evec[k][2*N], f);
            if (got != want) begin
                if (exp_err == 0) begin exp_fidx = 32'(k); exp_fvec = evec[k]; end
                exp_err++;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vec"},  {cin, a, b}, 0);
        chk({tag, "_flag"}, {busy, done, pass}, 0);
        chk({tag, "_err"},  err_count, 0);
        chk({tag, "_fidx"}, first_err_idx, 0);
        chk({tag, "_fvec"}, first_err_vec, 0);
    endtask

    // One run: per-cycle stimulus/status checks, then final report checks
    task automatic run(input logic m, input int f, input int abort_at, input int glitch_at);
        int nv;
        logic [VW-1:0] ev;
        fault = f;
        build(m, f);
        nv = evec.size();
        @(negedge clk); mode = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int j = 0; j < nv + int'(LAT) + 2; j++) begin
            if (j > 0) @(negedge clk);
            if (j == glitch_at) begin start = 1'b1; mode = ~m; end
            else start = 1'b0;
            if (j == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("abort");
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            ev = (j < nv) ? evec[j] : '0;
            chk("stim", {cin, a, b}, ev);
            chk("busy", busy, j < nv + int'(LAT));
            chk("done", done, j >= nv + int'(LAT));
        end
        chk("err_count", err_count, exp_err > 65535 ? 65535 : exp_err);
        chk("first_idx", first_err_idx, exp_fidx);
        chk("first_vec", first_err_vec, exp_fvec);
        chk("pass", pass, exp_err == 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; start2 = 1'b0; fault = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Model pins: first two LFSR vectors and stuck-at error count
        build(1'b0, 0);
        chk("model_v0", evec[0], 9'h010);
        chk("model_v1", evec[1], 9'h131);
        build(1'b1, 1);
        chk("model_stuck_err", exp_err, 256);

        run(1'b1, 0, -1, -1);
        chk("exh_ok_pass", pass, 1);
        run(1'b0, 0, -1, 60);
        run(1'b0, 2, -1, -1);
        run(1'b0, 2, 100, -1);
        run(1'b1, 1, -1, -1);
        chk("stuck_err", err_count, 256);
        chk("stuck_fidx", first_err_idx, 1);
        chk("stuck_fvec", first_err_vec, 9'h001);
        chk("stuck_pass", pass, 0);
        run(1'b0, 3, -1, -1);
        chk("lat_err_nonzero", err_count != 0, 1);
        chk("lat_fidx", first_err_idx, 0);

        // Zero-latency engine with prop/gen ignored
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int j = 0; j < 36; j++) begin
            if (j > 0) @(negedge clk);
            chk("pg_stim", {cin2, a2, b2}, (j < 32) ? j : 0);
            chk("pg_busy", busy2, j < 32);
            chk("pg_done", done2, j >= 32);
        end
        chk("pg_pass", pass2, 1);
        chk("pg_err", err2, 0);
        chk("pg_fvec", fvec2, 0);
        chk("pg_fidx", fidx2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
